// File: rtl/usb_tx_sequencer.sv
// USB 1.1 host transmit sequencer: serializes SYNC/PID/fields/CRC LSB-first
// at one bit per cycle, then drives EOP (2x SE0 + J). Stalls on stuffer pause.
module usb_tx_sequencer (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        start,
    input  logic [1:0]  pkt_type,
    input  logic [3:0]  pid,
    input  logic [6:0]  addr,
    input  logic [3:0]  endp,
    input  logic [63:0] data,
    input  logic        pause,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        se0,
    output logic        busy,
    output logic        done
);
    typedef enum logic [3:0] {
        IDLE, SYNC, PID, TOKEN, DATA, CRC5, CRC16, EOP_SE0, EOP_J
    } state_t;

    localparam logic [1:0] PT_TOKEN = 2'b00;
    localparam logic [1:0] PT_DATA  = 2'b01;
    localparam logic [1:0] PT_RSVD  = 2'b11;

    state_t      state;
    logic [6:0]  cnt;
    logic [1:0]  type_r;
    logic [3:0]  pid_r;
    logic [6:0]  addr_r;
    logic [3:0]  endp_r;
    logic [63:0] data_r;
    logic [4:0]  crc5;
    logic [15:0] crc16;

    logic [6:0]  cnt_inc;
    logic [7:0]  pid_byte;
    logic [10:0] tok;
    logic [4:0]  crc5_step;
    logic [15:0] crc16_step;
    logic [2:0]  crc5_idx;
    logic [3:0]  crc16_idx;

    // bit_out always holds the field bit currently on the wire, so the CRC
    // step folds it in, and the first CRC bit is taken from the stepped value.
    always_comb begin
        cnt_inc    = cnt + 7'd1;
        pid_byte   = {~pid_r, pid_r};
        tok        = {endp_r, addr_r};
        crc5_step  = {crc5[3:0], 1'b0} ^ ((bit_out ^ crc5[4]) ? 5'h05 : 5'h00);
        crc16_step = {crc16[14:0], 1'b0} ^ ((bit_out ^ crc16[15]) ? 16'h8005 : 16'h0000);
        crc5_idx   = 3'd4 - cnt_inc[2:0];
        crc16_idx  = 4'd15 - cnt_inc[3:0];
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state     <= IDLE;
            cnt       <= '0;
            type_r    <= '0;
            pid_r     <= '0;
            addr_r    <= '0;
            endp_r    <= '0;
            data_r    <= '0;
            crc5      <= 5'h1F;
            crc16     <= 16'hFFFF;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            se0       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && pkt_type != PT_RSVD) begin
                        type_r    <= pkt_type;
                        pid_r     <= pid;
                        addr_r    <= addr;
                        endp_r    <= endp;
                        data_r    <= data;
                        crc5      <= 5'h1F;
                        crc16     <= 16'hFFFF;
                        state     <= SYNC;
                        cnt       <= '0;
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SYNC: if (!pause) begin
                    if (cnt == 7'd7) begin
                        state   <= PID;
                        cnt     <= '0;
                        bit_out <= pid_byte[0];
                    end else begin
                        cnt     <= cnt_inc;
                        bit_out <= (cnt_inc == 7'd7);
                    end
                end
                PID: if (!pause) begin
                    if (cnt == 7'd7) begin
                        cnt <= '0;
                        if (type_r == PT_TOKEN) begin
                            state   <= TOKEN;
                            bit_out <= tok[0];
                        end else if (type_r == PT_DATA) begin
                            state   <= DATA;
                            bit_out <= data_r[0];
                        end else begin
                            state     <= EOP_SE0;
                            bit_out   <= 1'b0;
                            bit_valid <= 1'b0;
                            se0       <= 1'b1;
                        end
                    end else begin
                        cnt     <= cnt_inc;
                        bit_out <= pid_byte[cnt_inc[2:0]];
                    end
                end
                TOKEN: if (!pause) begin
                    crc5 <= crc5_step;
                    if (cnt == 7'd10) begin
                        state   <= CRC5;
                        cnt     <= '0;
                        bit_out <= ~crc5_step[4];
                    end else begin
                        cnt     <= cnt_inc;
                        bit_out <= tok[cnt_inc[3:0]];
                    end
                end
                DATA: if (!pause) begin
                    crc16 <= crc16_step;
                    if (cnt == 7'd63) begin
                        state   <= CRC16;
                        cnt     <= '0;
                        bit_out <= ~crc16_step[15];
                    end else begin
                        cnt     <= cnt_inc;
                        bit_out <= data_r[cnt_inc[5:0]];
                    end
                end
                CRC5: if (!pause) begin
                    if (cnt == 7'd4) begin
                        state     <= EOP_SE0;
                        cnt       <= '0;
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b0;
                        se0       <= 1'b1;
                    end else begin
                        cnt     <= cnt_inc;
                        bit_out <= ~crc5[crc5_idx];
                    end
                end
                CRC16: if (!pause) begin
                    if (cnt == 7'd15) begin
                        state     <= EOP_SE0;
                        cnt       <= '0;
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b0;
                        se0       <= 1'b1;
                    end else begin
                        cnt     <= cnt_inc;
                        bit_out <= ~crc16[crc16_idx];
                    end
                end
                EOP_SE0: begin
                    if (cnt == 7'd1) begin
                        state <= EOP_J;
                        cnt   <= '0;
                        se0   <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                EOP_J: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    bit_out   <= 1'b0;
                    bit_valid <= 1'b0;
                    se0       <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: packet framing, CRC residuals, pause, edges, reset.
module tb_usb_tx_sequencer;
    logic        clk;
    logic        rst_L;
    logic        start;
    logic [1:0]  pkt_type;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        pause;
    logic        bit_out;
    logic        bit_valid;
    logic        se0;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    usb_tx_sequencer dut (
        .clk(clk), .rst_L(rst_L), .start(start), .pkt_type(pkt_type),
        .pid(pid), .addr(addr), .endp(endp), .data(data), .pause(pause),
        .bit_out(bit_out), .bit_valid(bit_valid), .se0(se0), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] crc5_res(input logic [127:0] b, input int lo, input int n);
        logic [4:0] c;
        logic fb;
        c = 5'h1F;
        for (int i = 0; i < n; i++) begin
            fb = b[lo+i] ^ c[4];
            c = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_res(input logic [127:0] b, input int lo, input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = b[lo+i] ^ c[15];
            c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    function automatic bit is_pause_pt(input int k);
        return (k == 26) || (k == 56) || (k == 79) || (k == 95);
    endfunction

    // Launches one request and records the stream and event cycles (cycle 1 = first after start edge).
    task automatic run_pkt(input logic [1:0] t, input logic [3:0] p, input logic [6:0] a,
                           input logic [3:0] e, input logic [63:0] d, input bit do_pause,
                           output logic [127:0] bits, output int nbits, output int first_bv,
                           output int se0_first, output int se0_cnt, output int done_cyc,
                           output int busy_low, output int hold_bad);
        int   paused_for;
        bit   pend;
        logic held;
        bits = '0; nbits = 0; first_bv = -1; se0_first = -1; se0_cnt = 0;
        done_cyc = -1; busy_low = -1; hold_bad = 0; paused_for = -1; pend = 0; held = 0;
        pkt_type = t; pid = p; addr = a; endp = e; data = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pkt_type = 2'b00; pid = '0; addr = '0; endp = '0; data = '0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (bit_valid) begin
                if (first_bv < 0) first_bv = cyc;
                if (pend && bit_out !== held) hold_bad++;
                pend = 0;
                if (do_pause && paused_for != nbits && is_pause_pt(nbits)) begin
                    pause = 1'b1; held = bit_out; pend = 1; paused_for = nbits;
                end else begin
                    pause = 1'b0;
                    if (nbits < 128) bits[nbits] = bit_out;
                    nbits++;
                end
            end else begin
                pause = 1'b0;
            end
            if (se0) begin
                if (se0_first < 0) se0_first = cyc;
                se0_cnt++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (!busy && done_cyc >= 0) begin
                busy_low = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        pause = 1'b0;
    endtask

    task automatic test_reset();
        rst_L = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bit_out, bit_valid, se0, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000", {bit_out, bit_valid, se0, busy, done});
        end
        rst_L = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bit_valid, busy} !== 2'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 00", {bit_valid, busy});
        end
    endtask

    task automatic test_handshake();
        logic [127:0] b; int nb, fbv, sf, sc, dc, bl, hb;
        run_pkt(2'b10, 4'b0010, 7'h00, 4'h0, 64'h0, 0, b, nb, fbv, sf, sc, dc, bl, hb);
        n_checks++; if (nb !== 16) begin n_fail++; $display("FAIL ack_nbits: got %0d expected 16", nb); end
        n_checks++; if (b[15:0] !== 16'hD280) begin n_fail++; $display("FAIL ack_stream: got %h expected d280", b[15:0]); end
        n_checks++; if (fbv !== 1) begin n_fail++; $display("FAIL ack_first_bit: got %0d expected 1", fbv); end
        n_checks++; if (sf !== 17 || sc !== 2) begin n_fail++; $display("FAIL ack_se0: got first %0d count %0d expected 17/2", sf, sc); end
        n_checks++; if (dc !== 19) begin n_fail++; $display("FAIL ack_done: got %0d expected 19", dc); end
        n_checks++; if (bl !== 20) begin n_fail++; $display("FAIL ack_busy_low: got %0d expected 20", bl); end
    endtask

    task automatic test_token();
        logic [127:0] b; int nb, fbv, sf, sc, dc, bl, hb;
        run_pkt(2'b00, 4'b0001, 7'h05, 4'h4, 64'h0, 0, b, nb, fbv, sf, sc, dc, bl, hb);
        n_checks++; if (nb !== 32) begin n_fail++; $display("FAIL tok_nbits: got %0d expected 32", nb); end
        n_checks++; if (b[15:0] !== 16'hE180) begin n_fail++; $display("FAIL tok_sync_pid: got %h expected e180", b[15:0]); end
        n_checks++; if (b[26:16] !== {4'h4, 7'h05}) begin n_fail++; $display("FAIL tok_fields: got %h expected 205", b[26:16]); end
        n_checks++; if (crc5_res(b, 16, 16) !== 5'b01100) begin n_fail++; $display("FAIL tok_crc5: got %b expected 01100", crc5_res(b, 16, 16)); end
        n_checks++; if (dc !== 35 || sf !== 33) begin n_fail++; $display("FAIL tok_timing: got done %0d se0 %0d expected 35/33", dc, sf); end
    endtask

    task automatic test_data();
        logic [127:0] b; int nb, fbv, sf, sc, dc, bl, hb;
        run_pkt(2'b01, 4'b0011, 7'h00, 4'h0, 64'h0123_4567_89AB_CDEF, 0, b, nb, fbv, sf, sc, dc, bl, hb);
        n_checks++; if (nb !== 96) begin n_fail++; $display("FAIL data_nbits: got %0d expected 96", nb); end
        n_checks++; if (b[15:0] !== 16'hC380) begin n_fail++; $display("FAIL data_sync_pid: got %h expected c380", b[15:0]); end
        n_checks++; if (b[79:16] !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL data_payload: got %h expected 0123456789abcdef", b[79:16]); end
        n_checks++; if (crc16_res(b, 16, 80) !== 16'h800D) begin n_fail++; $display("FAIL data_crc16: got %h expected 800d", crc16_res(b, 16, 80)); end
        n_checks++; if (dc !== 99 || sf !== 97) begin n_fail++; $display("FAIL data_timing: got done %0d se0 %0d expected 99/97", dc, sf); end
    endtask

    task automatic test_pause();
        logic [127:0] b; int nb, fbv, sf, sc, dc, bl, hb;
        run_pkt(2'b01, 4'b0011, 7'h00, 4'h0, 64'h0123_4567_89AB_CDEF, 1, b, nb, fbv, sf, sc, dc, bl, hb);
        n_checks++; if (nb !== 96) begin n_fail++; $display("FAIL pause_nbits: got %0d expected 96", nb); end
        n_checks++; if (hb !== 0) begin n_fail++; $display("FAIL pause_hold: got %0d changed bits expected 0", hb); end
        n_checks++; if (b[15:0] !== 16'hC380 || b[79:16] !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL pause_stream: got %h/%h", b[15:0], b[79:16]); end
        n_checks++; if (crc16_res(b, 16, 80) !== 16'h800D) begin n_fail++; $display("FAIL pause_crc16: got %h expected 800d", crc16_res(b, 16, 80)); end
        n_checks++; if (dc !== 103) begin n_fail++; $display("FAIL pause_done: got %0d expected 103", dc); end
    endtask

    task automatic test_protocol_edges();
        int act, dc, bl, nv;
        logic [127:0] b; int nb, fbv, sf, sc, dc2, bl2, hb;
        // reserved type
        act = 0;
        pkt_type = 2'b11; pid = 4'b0010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (busy || bit_valid || se0 || done) act++;
            @(posedge clk); #1;
        end
        n_checks++; if (act !== 0) begin n_fail++; $display("FAIL reserved_idle: got %0d active cycles expected 0", act); end
        // start while busy
        pkt_type = 2'b10; pid = 4'b0010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc = -1; bl = -1; act = 0; nv = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 5) begin start = 1'b1; pkt_type = 2'b01; end else start = 1'b0;
            if (bit_valid) nv++;
            if (done && dc < 0) dc = cyc;
            if (dc >= 0 && !busy && bl < 0) bl = cyc;
            if (bl >= 0 && (busy || bit_valid)) act++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++; if (dc !== 19 || bl !== 20 || nv !== 16) begin n_fail++; $display("FAIL busy_start_ignored: got done %0d busylow %0d bits %0d expected 19/20/16", dc, bl, nv); end
        n_checks++; if (act !== 0) begin n_fail++; $display("FAIL busy_no_queue: got %0d active cycles expected 0", act); end
        // back to back: second start lands in the cycle after done
        run_pkt(2'b10, 4'b0010, 7'h00, 4'h0, 64'h0, 0, b, nb, fbv, sf, sc, dc2, bl2, hb);
        run_pkt(2'b10, 4'b1010, 7'h00, 4'h0, 64'h0, 0, b, nb, fbv, sf, sc, dc2, bl2, hb);
        n_checks++; if (fbv !== 1 || dc2 !== 19) begin n_fail++; $display("FAIL back_to_back: got first %0d done %0d expected 1/19", fbv, dc2); end
        n_checks++; if (b[15:0] !== 16'h5A80) begin n_fail++; $display("FAIL back_to_back_stream: got %h expected 5a80", b[15:0]); end
    endtask

    task automatic test_reset_mid();
        int sc;
        logic [127:0] b; int nb, fbv, sf, sc2, dc, bl, hb;
        pkt_type = 2'b01; pid = 4'b0011; data = 64'hFFFF_0000_AAAA_5555; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 50; cyc++) begin
            @(posedge clk); #1;
        end
        n_checks++; if ({bit_valid, busy} !== 2'b11) begin n_fail++; $display("FAIL mid_active: got %b expected 11", {bit_valid, busy}); end
        rst_L = 1'b0;
        #1;
        n_checks++; if ({bit_out, bit_valid, se0, busy, done} !== 5'b0) begin n_fail++; $display("FAIL mid_async_reset: got %b expected 00000", {bit_out, bit_valid, se0, busy, done}); end
        sc = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (se0 || bit_valid || busy) sc++;
        end
        rst_L = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (se0 || bit_valid || busy || done) sc++;
        end
        n_checks++; if (sc !== 0) begin n_fail++; $display("FAIL mid_no_eop: got %0d active cycles expected 0", sc); end
        run_pkt(2'b10, 4'b0010, 7'h00, 4'h0, 64'h0, 0, b, nb, fbv, sf, sc2, dc, bl, hb);
        n_checks++; if (dc !== 19 || b[15:0] !== 16'hD280) begin n_fail++; $display("FAIL post_reset_ack: got done %0d stream %h expected 19/d280", dc, b[15:0]); end
    endtask

    initial begin
        rst_L = 1'b0; start = 1'b0; pkt_type = '0; pid = '0; addr = '0;
        endp = '0; data = '0; pause = 1'b0;
        test_reset();
        test_handshake();
        test_token();
        test_data();
        test_pause();
        test_protocol_edges();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
